// File: rtl/exec_unit.sv
// Execute stage behind the register file: one ALU op or a multi-cycle shift-add
// multiply, then a single-cycle write-back pulse on wr/rd/ad plus {Z,N,C,V} flags.
module exec_unit #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [AW-1:0] dst,
  output logic          busy,
  output logic          wr,
  output logic [DW-1:0] rd,
  output logic [AW-1:0] ad,
  output logic [3:0]    flags
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [AW-1:0]   dst_q;
  logic [DW-1:0]   hi;
  logic [2*DW-1:0] acc;
  logic [2*DW-1:0] mcand;
  logic [CW-1:0]   cnt;

  logic [DW:0]     alu_wide;
  logic [DW-1:0]   alu_res;
  logic            alu_c;
  logic            alu_v;
  logic            alu_wr;
  logic            alu_upd;
  logic            cin;
  logic [2*DW-1:0] acc_next;

  assign busy     = (state != IDLE);
  assign cin      = flags[1];
  assign alu_res  = alu_wide[DW-1:0];
  // b_q doubles as the multiplier shift register while in MUL
  assign acc_next = acc + (b_q[0] ? mcand : '0);

  always_comb begin
    alu_wide = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_wr   = 1'b1;
    alu_upd  = 1'b1;
    case (op_q)
      4'h0, 4'h8: begin
        alu_wide = {1'b0, a_q} + {1'b0, b_q} + {{DW{1'b0}}, (op_q == 4'h8) & cin};
        alu_c    = alu_wide[DW];
        alu_v    = (a_q[DW-1] == b_q[DW-1]) && (alu_wide[DW-1] != a_q[DW-1]);
      end
      4'h1, 4'h9, 4'hD: begin
        alu_wide = {1'b0, a_q} - {1'b0, b_q} - {{DW{1'b0}}, (op_q == 4'h9) & cin};
        alu_c    = alu_wide[DW];
        alu_v    = (a_q[DW-1] != b_q[DW-1]) && (alu_wide[DW-1] != a_q[DW-1]);
        alu_wr   = (op_q != 4'hD);
      end
      4'h2: alu_wide = {1'b0, a_q & b_q};
      4'h3: alu_wide = {1'b0, a_q | b_q};
      4'h4: alu_wide = {1'b0, a_q ^ b_q};
      4'h5: alu_wide = {1'b0, ~a_q};
      4'h6: begin
        alu_wide = {1'b0, a_q[DW-2:0], 1'b0};
        alu_c    = a_q[DW-1];
      end
      4'h7: begin
        alu_wide = {2'b00, a_q[DW-1:1]};
        alu_c    = a_q[0];
      end
      4'hA: alu_wide = {1'b0, b_q};
      4'hC: begin
        alu_wide = {1'b0, hi};
        alu_upd  = 1'b0;
      end
      default: begin
        alu_wr  = 1'b0;
        alu_upd = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr    <= 1'b0;
      rd    <= '0;
      ad    <= '0;
      flags <= '0;
      hi    <= '0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      dst_q <= '0;
      acc   <= '0;
      mcand <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            dst_q <= dst;
            acc   <= '0;
            mcand <= {{DW{1'b0}}, a};
            cnt   <= '0;
            state <= (op == 4'hB) ? MUL : EXEC;
          end
        end
        EXEC: begin
          if (alu_wr) begin
            rd <= alu_res;
            ad <= dst_q;
            wr <= 1'b1;
          end
          if (op_q == 4'hC) begin
            flags[3:2] <= {hi == '0, hi[DW-1]};
          end else if (alu_upd) begin
            flags <= {alu_res == '0, alu_res[DW-1], alu_c, alu_v};
          end
          state <= WB;
        end
        MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          b_q   <= b_q >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(DW-1)) begin
            rd    <= acc_next[DW-1:0];
            hi    <= acc_next[2*DW-1:DW];
            ad    <= dst_q;
            wr    <= 1'b1;
            flags <= {acc_next == '0, acc_next[DW-1], acc_next[2*DW-1:DW] != '0, 1'b0};
            cnt   <= '0;
            state <= WB;
          end
        end
        WB: begin
          wr    <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model of the opcode rules.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [5:0] dst = '0;
  logic       busy;
  logic       wr;
  logic [7:0] rd;
  logic [5:0] ad;
  logic [3:0] flags;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] m_rd = '0;
  logic [7:0] m_hi = '0;
  logic [5:0] m_ad = '0;
  logic [3:0] m_flags = '0;
  logic       exp_wr;

  exec_unit #(.DW(8), .AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .dst(dst),
    .busy(busy), .wr(wr), .rd(rd), .ad(ad), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the opcode rules
  task automatic model_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [5:0] d);
    int ua, ub, sa, sb, ci, r, sr, prod, hi_i;
    logic [7:0] rr;
    logic c, v;
    ua = int'(x); ub = int'(y);
    sa = int'($signed(x)); sb = int'($signed(y));
    ci = int'(m_flags[1]);
    r = 0; sr = 0; c = 1'b0; v = 1'b0; prod = 0; hi_i = 0;
    exp_wr = 1'b1;
    case (o)
      4'h0: begin r = ua + ub; sr = sa + sb; c = (r > 255); end
      4'h8: begin r = ua + ub + ci; sr = sa + sb + ci; c = (r > 255); end
      4'h1, 4'hD: begin r = ua - ub; sr = sa - sb; c = (ua < ub); end
      4'h9: begin r = ua - ub - ci; sr = sa - sb - ci; c = (ua < ub + ci); end
      4'h2: r = ua & ub;
      4'h3: r = ua | ub;
      4'h4: r = ua ^ ub;
      4'h5: r = 255 - ua;
      4'h6: begin r = ua * 2; c = (ua >= 128); end
      4'h7: begin r = ua / 2; c = ((ua % 2) == 1); end
      4'hA: r = ub;
      4'hB: begin prod = ua * ub; r = prod % 256; hi_i = prod / 256; end
      4'hC: r = int'(m_hi);
      default: exp_wr = 1'b0;
    endcase
    if (o == 4'hD) exp_wr = 1'b0;
    if (o == 4'h0 || o == 4'h8 || o == 4'h1 || o == 4'h9 || o == 4'hD)
      v = (sr > 127) || (sr < -128);
    rr = r[7:0];
    if (o == 4'hB) begin
      m_hi = hi_i[7:0];
      m_flags = {prod == 0, rr[7], hi_i != 0, 1'b0};
    end else if (o == 4'hC) begin
      m_flags[3:2] = {rr == 8'h00, rr[7]};
    end else if (o != 4'hE && o != 4'hF) begin
      m_flags = {rr == 8'h00, rr[7], c, v};
    end
    if (exp_wr) begin
      m_rd = rr;
      m_ad = d;
    end
  endtask

  // Issue one op, watch 16 cycles for wr pulses, optionally pulse start while busy
  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [5:0] d, input int pulse_at);
    int wr_cnt, first, lat;
    wr_cnt = 0; first = -1;
    lat = (o == 4'hB) ? 8 : 1;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; dst = d;
    model_op(o, x, y, d);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (wr) begin
        wr_cnt++;
        if (first < 0) first = i;
      end
      start = (i == pulse_at);
      if (i == pulse_at) begin op = 4'h0; a = 8'h11; b = 8'h22; dst = 6'd63; end
    end
    n_checks++;
    if (wr_cnt !== (exp_wr ? 1 : 0)) begin
      n_fail++;
      $display("[TB] FAIL wr_count op=%h: got %0d expected %0d", o, wr_cnt, exp_wr ? 1 : 0);
    end
    if (exp_wr) begin
      n_checks++;
      if (first !== lat + 1) begin
        n_fail++;
        $display("[TB] FAIL wr_latency op=%h: got edge k+%0d expected edge k+%0d", o, first - 1, lat);
      end
      n_checks++;
      if (rd !== m_rd || ad !== m_ad) begin
        n_fail++;
        $display("[TB] FAIL result op=%h a=%h b=%h: got rd=%h ad=%0d expected rd=%h ad=%0d", o, x, y, rd, ad, m_rd, m_ad);
      end
    end
    n_checks++;
    if (flags !== m_flags || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flags op=%h a=%h b=%h: got flags=%b busy=%b expected flags=%b busy=0", o, x, y, flags, busy, m_flags);
    end
  endtask

  task automatic test_reset;
    int wr_cnt;
    wr_cnt = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, wr, rd, ad, flags} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got busy=%b wr=%b rd=%h ad=%0d flags=%b expected all 0", busy, wr, rd, ad, flags);
    end
    rst_n = 1'b1;
    run_op(4'h0, 8'h10, 8'h25, 6'd3, 0);
    @(negedge clk);
    start = 1'b1; op = 4'hB; a = 8'd200; b = 8'd3; dst = 6'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, wr, rd, flags} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_mul: got busy=%b wr=%b rd=%h flags=%b expected all 0", busy, wr, rd, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wr) wr_cnt++;
    end
    n_checks++;
    if (wr_cnt !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL no_wr_after_reset: got %0d pulses busy=%b expected 0 pulses busy=0", wr_cnt, busy);
    end
    m_rd = '0; m_hi = '0; m_ad = '0; m_flags = '0;
    run_op(4'hC, 8'h00, 8'h00, 6'd1, 0);
    n_checks++;
    if (rd !== 8'h00 || flags !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL hi_after_reset: got rd=%h flags=%b expected rd=00 flags=1000", rd, flags);
    end
  endtask

  task automatic test_add;
    run_op(4'h0, 8'h7F, 8'h01, 6'd5, 0);
    n_checks++;
    if (rd !== 8'h80 || ad !== 6'd5 || flags !== 4'b0101) begin
      n_fail++;
      $display("[TB] FAIL add_overflow: got rd=%h ad=%0d flags=%b expected rd=80 ad=5 flags=0101", rd, ad, flags);
    end
  endtask

  task automatic test_sub_sbb;
    run_op(4'h1, 8'h05, 8'h05, 6'd2, 0);
    n_checks++;
    if (rd !== 8'h00 || flags !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL sub_zero: got rd=%h flags=%b expected rd=00 flags=1000", rd, flags);
    end
    run_op(4'hD, 8'h03, 8'h04, 6'd7, 0);
    run_op(4'h9, 8'h00, 8'h00, 6'd4, 0);
    n_checks++;
    if (rd !== 8'hFF || flags !== 4'b0110) begin
      n_fail++;
      $display("[TB] FAIL sbb_borrow: got rd=%h flags=%b expected rd=FF flags=0110", rd, flags);
    end
  endtask

  task automatic test_mul;
    run_op(4'hB, 8'd200, 8'd3, 6'd9, 0);
    n_checks++;
    if (rd !== 8'h58 || ad !== 6'd9 || flags !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL mul_200x3: got rd=%h ad=%0d flags=%b expected rd=58 ad=9 flags=0010", rd, ad, flags);
    end
    run_op(4'hC, 8'h00, 8'h00, 6'd10, 0);
    n_checks++;
    if (rd !== 8'h02 || flags !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL mfhi: got rd=%h flags=%b expected rd=02 flags=0010", rd, flags);
    end
  endtask

  task automatic test_busy_ignore;
    run_op(4'hB, 8'h0F, 8'h11, 6'd12, 3);
    n_checks++;
    if (rd !== 8'hFF || ad !== 6'd12) begin
      n_fail++;
      $display("[TB] FAIL start_while_busy: got rd=%h ad=%0d expected rd=FF ad=12", rd, ad);
    end
    run_op(4'hD, 8'h03, 8'h04, 6'd13, 0);
    n_checks++;
    if (flags !== 4'b0110) begin
      n_fail++;
      $display("[TB] FAIL cmp: got flags=%b expected 0110", flags);
    end
  endtask

  task automatic test_shift_nop;
    run_op(4'h6, 8'h81, 8'h00, 6'd14, 0);
    n_checks++;
    if (rd !== 8'h02 || flags !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL shl: got rd=%h flags=%b expected rd=02 flags=0010", rd, flags);
    end
    run_op(4'h7, 8'h01, 8'h00, 6'd15, 0);
    n_checks++;
    if (rd !== 8'h00 || flags !== 4'b1010) begin
      n_fail++;
      $display("[TB] FAIL shr: got rd=%h flags=%b expected rd=00 flags=1010", rd, flags);
    end
    run_op(4'hE, 8'h55, 8'hAA, 6'd16, 0);
    n_checks++;
    if (flags !== 4'b1010) begin
      n_fail++;
      $display("[TB] FAIL nop_flags: got flags=%b expected 1010", flags);
    end
  endtask

  // Start held high: the second op must be taken exactly three edges after the first
  task automatic test_back_to_back;
    logic [7:0] rd1, rd2;
    model_op(4'h0, 8'h10, 8'h22, 6'd20);
    rd1 = m_rd;
    model_op(4'h4, 8'hF0, 8'h0F, 6'd21);
    rd2 = m_rd;
    @(negedge clk);
    start = 1'b1; op = 4'h0; a = 8'h10; b = 8'h22; dst = 6'd20;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (wr !== (i == 2 || i == 5) || busy !== (i != 3 && i <= 5)) begin
        n_fail++;
        $display("[TB] FAIL b2b_timing cycle %0d: got wr=%b busy=%b expected wr=%b busy=%b", i, wr, busy, (i == 2 || i == 5), (i != 3 && i <= 5));
      end
      if (i == 2 || i == 5) begin
        n_checks++;
        if (rd !== ((i == 2) ? rd1 : rd2) || ad !== ((i == 2) ? 6'd20 : 6'd21)) begin
          n_fail++;
          $display("[TB] FAIL b2b_data cycle %0d: got rd=%h ad=%0d expected rd=%h", i, rd, ad, (i == 2) ? rd1 : rd2);
        end
      end
      if (i == 1) begin op = 4'h4; a = 8'hF0; b = 8'h0F; dst = 6'd21; end
      if (i == 4) start = 1'b0;
    end
  endtask

  task automatic test_random;
    logic [3:0] o;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(15, 0));
      run_op(o, 8'($urandom), 8'($urandom), 6'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sbb();
    test_mul();
    test_busy_ignore();
    test_shift_nop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
